// File: rtl/orpheus_pkg.sv
// ---------------------------------------------------------------------------
// orpheus_pkg
// Types shared between the sine-time sequencer and the sine source.
//   sample_t         : signed 32-bit sample/time quantity
//   sinetime_state_t : sequencer FSM states
//   clamp_period()   : raises a requested period to the legal minimum
// ---------------------------------------------------------------------------
package orpheus_pkg;

    typedef logic signed [31:0] sample_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2
    } sinetime_state_t;

    function automatic sample_t clamp_period(input sample_t p, input sample_t min_p);
        return (p < min_p) ? min_p : p;
    endfunction

endpackage

// File: rtl/mod_tickdiv.sv
// ---------------------------------------------------------------------------
// mod_tickdiv
// Free-running divider producing one sample tick every CLK_DIV clocks.
// The counter runs 0..CLK_DIV-1 and wraps; o_tick is high while it sits at
// CLK_DIV-1.
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset (counter to 0)
//   o_tick : one-cycle tick strobe
// ---------------------------------------------------------------------------
module mod_tickdiv #(
    parameter int unsigned CLK_DIV = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] L_LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == L_LAST);
    assign o_tick = w_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mod_sinetime.sv
// ---------------------------------------------------------------------------
// mod_sinetime
// Generates the time index and period for a downstream sine source. A note
// gate starts/stops the waveform; stopping is deferred to the end of the
// current period so the output never cuts mid-cycle. A one-deep pending slot
// accepts new periods, which take effect only at a period boundary (or at
// the next tick when idle).
//   i_clk, i_rst         : clock, asynchronous active-high reset
//   i_period/_valid      : requested period (samples), offered by handshake
//   o_period_ready       : pending slot empty
//   i_gate               : note on/off
//   o_time, o_period     : registered sample index and active period
//   o_sample_valid       : one-cycle pulse per new o_time/o_period pair
//   o_active             : FSM in RUN or STOP
// ---------------------------------------------------------------------------
module mod_sinetime
    import orpheus_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 1024,
    parameter int          MIN_PERIOD = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic signed [31:0] i_period,
    input  logic               i_period_valid,
    output logic               o_period_ready,
    input  logic               i_gate,
    output logic signed [31:0] o_time,
    output logic signed [31:0] o_period,
    output logic               o_sample_valid,
    output logic               o_active
);

    localparam sample_t L_MIN_PERIOD = sample_t'(MIN_PERIOD);

    sinetime_state_t r_state;
    sample_t         r_time;
    sample_t         r_period;
    sample_t         r_pend;
    logic            r_pend_full;
    logic            r_sample_valid;
    logic            r_active;

    logic            w_tick;
    logic            w_accept;
    logic            w_last;

    mod_tickdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_tickdiv (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    assign w_accept = i_period_valid && !r_pend_full;
    // ">=" rather than "==" also folds an out-of-range time back to 0.
    assign w_last   = (r_time >= (r_period - 32'sd1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_time         <= '0;
            r_period       <= L_MIN_PERIOD;
            r_pend         <= L_MIN_PERIOD;
            r_pend_full    <= 1'b0;
            r_sample_valid <= 1'b0;
            r_active       <= 1'b0;
        end else begin
            r_sample_valid <= w_tick;

            // Accept needs an empty slot and consume needs a full one, so the
            // two never coincide; a period taken on a wrap-tick waits a cycle.
            if (w_accept) begin
                r_pend      <= clamp_period(i_period, L_MIN_PERIOD);
                r_pend_full <= 1'b1;
            end

            if (w_tick) begin
                unique case (r_state)
                    StIdle: begin
                        r_time <= '0;
                        if (r_pend_full) begin
                            r_period    <= r_pend;
                            r_pend_full <= 1'b0;
                        end
                        if (i_gate) begin
                            r_state  <= StRun;
                            r_active <= 1'b1;
                        end else begin
                            r_active <= 1'b0;
                        end
                    end
                    StRun, StStop: begin
                        if (w_last) begin
                            r_time <= '0;
                            if (r_pend_full) begin
                                r_period    <= r_pend;
                                r_pend_full <= 1'b0;
                            end
                        end else begin
                            r_time <= r_time + 32'sd1;
                        end
                        if (i_gate) begin
                            r_state  <= StRun;
                            r_active <= 1'b1;
                        end else if ((r_state == StStop) && w_last) begin
                            r_state  <= StIdle;
                            r_active <= 1'b0;
                        end else begin
                            r_state  <= StStop;
                            r_active <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= StIdle;
                        r_time   <= '0;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_period_ready = !r_pend_full;
    assign o_time         = r_time;
    assign o_period       = r_period;
    assign o_sample_valid = r_sample_valid;
    assign o_active       = r_active;

endmodule
